ast_sc_fifo: RTL and testbench
==============================

# ast_sc_fifo

Parametrised single-clock Avalon-ST FIFO with independent ready latency on both sides, packet (SOP/EOP/empty) transport, optional store-and-forward mode, fill level, and almost-full/almost-empty thresholds. Successor to the word-only fifo block. It sits between Avalon-ST stream producers and consumers in the data path, for rate decoupling and packet buffering.

## Interface
- DATABITS_PER_SYMBOL, 8, bits per symbol
- SYMBOLS_PER_BEAT, 4, symbols per beat
- DATA_WIDTH, DATABITS_PER_SYMBOL*SYMBOLS_PER_BEAT, derived
- EMPTY_WIDTH, max(1,$clog2(SYMBOLS_PER_BEAT)), derived
- ADDR_WIDTH, 4, log2 of entry count; DEPTH = 2**ADDR_WIDTH
- READY_LATENCY, 2, Avalon-ST ready latency on sink and source; legal range 0..4, and READY_LATENCY < DEPTH
- STORE_FORWARD, 0, 1 = source emits only complete packets
- ALMOST_FULL_TH, DEPTH-2, almost_full_o threshold (entries)
- ALMOST_EMPTY_TH, 2, almost_empty_o threshold (entries)
- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- snk_data_i  in  DATA_WIDTH  sink data
- snk_valid_i  in  1  sink beat valid
- snk_sop_i / snk_eop_i  in  1 each  start / end of packet
- snk_empty_i  in  EMPTY_WIDTH  unused symbols on EOP beat
- snk_ready_o  out  1  sink ready
- src_data_o  out  DATA_WIDTH  source data
- src_valid_o  out  1  source beat valid
- src_sop_o / src_eop_o  out  1 each  start / end of packet
- src_empty_o  out  EMPTY_WIDTH  unused symbols
- src_ready_i  in  1  downstream ready
- fill_level_o  out  ADDR_WIDTH+1  stored entries, 0..DEPTH
- almost_full_o  out  1  fill_level_o >= ALMOST_FULL_TH
- almost_empty_o  out  1  fill_level_o <= ALMOST_EMPTY_TH
- overflow_o  out  1  sticky: sink beat arrived without permission

## Operation
- Entry = {data, sop, eop, empty}; DEPTH-entry array, rd/wr pointers ADDR_WIDTH+1 bits, MSB is wrap bit; wrap silent.
- fill_level_o register: +1 on write only, -1 on read only, unchanged on simultaneous read+write.
- snk_ready_o = !rst_i && (fill_level_o + READY_LATENCY < DEPTH); guarantees room for all beats already granted.
- snk_rdy_hist: RL-deep shift of snk_ready_o; grant(t) = snk_ready_o(t-RL) (RL=0: snk_ready_o(t)).
- Write when snk_valid_i && grant. snk_valid_i without grant: beat dropped, overflow_o set, held until reset.
- pkt_cnt (ADDR_WIDTH+1 bits): +1 on write with eop, -1 on read with eop; only used when STORE_FORWARD=1.
- Source permission perm(t) = src_ready_i(t-RL) via RL-deep history (RL=0: src_ready_i).
- avail = fill_level_o != 0, and when STORE_FORWARD=1 additionally (pkt_cnt != 0 || fill_level_o == DEPTH); full-without-EOP falls back to cut-through to avoid deadlock.
- src_valid_o = perm && avail; when high, src_* show head entry (show-ahead) and the entry pops at that edge. src_* data fields are don't-care while src_valid_o low.
- USE of sop/eop/empty is transparent: no packet-legality checking.

## Timing
- rst_i asserted: pointers, fill_level_o, pkt_cnt, both histories, overflow_o clear immediately; outputs: snk_ready_o 0, src_valid_o 0, fill_level_o 0, almost_full_o 0 (ALMOST_FULL_TH>0), almost_empty_o 1, overflow_o 0.
- Reset mid-operation: all contents discarded; beats arriving within RL cycles after release have no grant and set overflow_o.
- Write-to-source latency: entry written at edge t is eligible in cycle t+1 (src_valid_o at t+1 if perm).
- Full: fill = DEPTH is reachable only via granted in-flight beats; snk_ready_o already low for RL cycles beforehand.
- Empty with perm high: src_valid_o 0, no pop, no pointer change.
- Simultaneous write and read at fill=1: pop old head, store new; fill stays 1.
- almost_* are combinational from fill_level_o, valid same cycle.

## Test plan
- RL=2, DEPTH=16: write 16 beats 0x00000001..0x00000010 with snk_valid_i only on granted cycles, src_ready_i low -> snk_ready_o falls at fill 14, fill reaches 16, overflow_o 0.
- Then src_ready_i high continuously -> src_valid_o first high 2 cycles later, beats emerge in order 1..16, fill returns 0, almost_empty_o 1.
- snk_valid_i with data 0xDEADBEEF two cycles after snk_ready_o low -> beat dropped, overflow_o 1 and stays 1 until rst_i.
- STORE_FORWARD=1: write 5-beat packet (sop beat 0, eop beat 4, empty=2), src_ready_i high -> src_valid_o stays 0 until cycle after EOP write, then 5 beats with src_empty_o=2 on last.
- STORE_FORWARD=1, 20-beat packet without EOP until beat 20 -> at fill 16 source releases cut-through, all 20 beats delivered, no overflow.
- Assert rst_i mid-stream at fill 7 -> fill_level_o 0, src_valid_o 0, snk_ready_o 0 same cycle; after release snk_ready_o 1 next cycle.

Source files
------------

// File: rtl/ast_sc_fifo.sv
// ast_sc_fifo: single-clock Avalon-ST FIFO carrying {data, sop, eop, empty}
// entries, with the same ready latency on the sink and source sides.
// Optional store-and-forward mode holds the source back until a complete
// packet is stored. An oversized packet that fills the array switches to
// cut-through until its EOP leaves, so the FIFO cannot deadlock.
// Fill level, almost-full/almost-empty flags and a sticky overflow flag are
// also provided.

module ast_sc_fifo #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int DATA_WIDTH          = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  parameter int EMPTY_WIDTH         = (SYMBOLS_PER_BEAT > 1) ? $clog2(SYMBOLS_PER_BEAT) : 1,
  parameter int ADDR_WIDTH          = 4,
  parameter int READY_LATENCY       = 2,
  parameter int STORE_FORWARD       = 0,
  parameter int ALMOST_FULL_TH      = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH     = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // sink side
  input  logic [DATA_WIDTH-1:0]  snk_data_i,
  input  logic                   snk_valid_i,
  input  logic                   snk_sop_i,
  input  logic                   snk_eop_i,
  input  logic [EMPTY_WIDTH-1:0] snk_empty_i,
  output logic                   snk_ready_o,
  // source side
  output logic [DATA_WIDTH-1:0]  src_data_o,
  output logic                   src_valid_o,
  output logic                   src_sop_o,
  output logic                   src_eop_o,
  output logic [EMPTY_WIDTH-1:0] src_empty_o,
  input  logic                   src_ready_i,
  // status
  output logic [ADDR_WIDTH:0]    fill_level_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic                   overflow_o
);

  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam int ENTRY_W     = DATA_WIDTH + 2 + EMPTY_WIDTH;
  localparam int RDY_LIMIT_I = DEPTH - READY_LATENCY;

  // Level constants sized to the fill counter so every compare is width-matched.
  localparam logic [ADDR_WIDTH:0] DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] RDY_LIMIT = RDY_LIMIT_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_LVL    = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL    = ALMOST_EMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Parameter sanity: ready latency must fit the pipeline and leave headroom.
  if (READY_LATENCY < 0 || READY_LATENCY > 4) begin : g_bad_rl
    $error("ast_sc_fifo: READY_LATENCY must be within 0..4");
  end
  if (READY_LATENCY >= DEPTH) begin : g_bad_depth
    $error("ast_sc_fifo: READY_LATENCY must be smaller than the FIFO depth");
  end
  if (ALMOST_FULL_TH < 0 || ALMOST_FULL_TH > DEPTH ||
      ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH) begin : g_bad_th
    $error("ast_sc_fifo: almost thresholds must lie within 0..DEPTH");
  end

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   fill_level;
  logic                  snk_ready;
  logic                  src_valid;
  logic                  grant;
  logic                  perm;
  logic                  avail;
  logic                  wr_en;
  logic                  rd_en;
  logic                  overflow;
  logic                  head_eop;

  assign wr_entry   = {snk_data_i, snk_sop_i, snk_eop_i, snk_empty_i};
  assign head_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign head_eop   = head_entry[EMPTY_WIDTH];

  // Sink stays ready only while every beat that may still be granted has room.
  assign snk_ready = !rst_i && (fill_level < RDY_LIMIT);

  assign wr_en     = snk_valid_i && grant;
  assign src_valid = perm && avail;
  assign rd_en     = src_valid;

  // Ready histories: a beat granted now was enabled READY_LATENCY cycles ago.
  if (READY_LATENCY == 0) begin : g_rl0
    assign grant = snk_ready;
    assign perm  = src_ready_i;
  end else begin : g_rl
    logic [READY_LATENCY-1:0] snk_rdy_hist;
    logic [READY_LATENCY-1:0] src_rdy_hist;

    // Shift both ready signals through READY_LATENCY stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        snk_rdy_hist <= '0;
        src_rdy_hist <= '0;
      end else begin
        snk_rdy_hist[0] <= snk_ready;
        src_rdy_hist[0] <= src_ready_i;
        for (int i = 1; i < READY_LATENCY; i++) begin
          snk_rdy_hist[i] <= snk_rdy_hist[i-1];
          src_rdy_hist[i] <= src_rdy_hist[i-1];
        end
      end
    end

    assign grant = snk_rdy_hist[READY_LATENCY-1];
    assign perm  = src_rdy_hist[READY_LATENCY-1];
  end

  // Entry storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_entry;
    end
  end

  // Pointers wrap silently; the extra MSB tells full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + LVL_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + LVL_ONE;
      end
    end
  end

  // Fill level moves only when exactly one of write/read happens.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_level <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   fill_level <= fill_level + LVL_ONE;
        2'b01:   fill_level <= fill_level - LVL_ONE;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // A sink beat without a grant is lost; remember that until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow <= 1'b0;
    end else if (snk_valid_i && !grant) begin
      overflow <= 1'b1;
    end
  end

  if (STORE_FORWARD != 0) begin : g_sf
    logic [ADDR_WIDTH:0] pkt_cnt;
    logic                cut_thru;
    logic                wr_eop;
    logic                rd_eop;

    assign wr_eop = wr_en && snk_eop_i;
    assign rd_eop = rd_en && head_eop;

    // Count complete packets held in the array.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pkt_cnt <= '0;
      end else begin
        case ({wr_eop, rd_eop})
          2'b10:   pkt_cnt <= pkt_cnt + LVL_ONE;
          2'b01:   pkt_cnt <= pkt_cnt - LVL_ONE;
          default: pkt_cnt <= pkt_cnt;
        endcase
      end
    end

    // Once a packet larger than the array fills it, keep streaming that
    // packet out until its EOP leaves; otherwise the first pop would drop
    // below full and the source would stall forever with the sink closed.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cut_thru <= 1'b0;
      end else if (rd_eop) begin
        cut_thru <= 1'b0;
      end else if (fill_level == DEPTH_LVL && pkt_cnt == '0) begin
        cut_thru <= 1'b1;
      end
    end

    assign avail = (fill_level != '0) &&
                   ((pkt_cnt != '0) || (fill_level == DEPTH_LVL) || cut_thru);
  end else begin : g_ct
    assign avail = (fill_level != '0);
  end

  assign snk_ready_o    = snk_ready;
  assign src_valid_o    = src_valid;
  assign src_data_o     = head_entry[ENTRY_W-1 -: DATA_WIDTH];
  assign src_sop_o      = head_entry[EMPTY_WIDTH+1];
  assign src_eop_o      = head_eop;
  assign src_empty_o    = head_entry[EMPTY_WIDTH-1:0];
  assign fill_level_o   = fill_level;
  assign almost_full_o  = (fill_level >= AF_LVL);
  assign almost_empty_o = (fill_level <= AE_LVL);
  assign overflow_o     = overflow;

endmodule

// File: tb/tb_ast_sc_fifo.sv
// Directed self-checking bench for ast_sc_fifo: one cut-through instance (a_*)
// and one store-and-forward instance (b_*), both with ready latency 2, depth 16.

module tb_ast_sc_fifo;

  logic        clk;
  int          tests_run;
  int          tests_failed;

  logic        a_rst, a_snk_valid, a_snk_sop, a_snk_eop, a_snk_ready;
  logic [31:0] a_snk_data, a_src_data;
  logic [1:0]  a_snk_empty, a_src_empty;
  logic        a_src_valid, a_src_sop, a_src_eop, a_src_ready;
  logic [4:0]  a_fill;
  logic        a_af, a_ae, a_ovf;

  logic        b_rst, b_snk_valid, b_snk_sop, b_snk_eop, b_snk_ready;
  logic [31:0] b_snk_data, b_src_data;
  logic [1:0]  b_snk_empty, b_src_empty;
  logic        b_src_valid, b_src_sop, b_src_eop, b_src_ready;
  logic [4:0]  b_fill;
  logic        b_af, b_ae, b_ovf;

  logic        a_h1, a_h2, b_h1, b_h2;

  ast_sc_fifo #(.READY_LATENCY(2), .ADDR_WIDTH(4), .STORE_FORWARD(0)) dut_a (
    .clk_i(clk), .rst_i(a_rst),
    .snk_data_i(a_snk_data), .snk_valid_i(a_snk_valid), .snk_sop_i(a_snk_sop),
    .snk_eop_i(a_snk_eop), .snk_empty_i(a_snk_empty), .snk_ready_o(a_snk_ready),
    .src_data_o(a_src_data), .src_valid_o(a_src_valid), .src_sop_o(a_src_sop),
    .src_eop_o(a_src_eop), .src_empty_o(a_src_empty), .src_ready_i(a_src_ready),
    .fill_level_o(a_fill), .almost_full_o(a_af), .almost_empty_o(a_ae),
    .overflow_o(a_ovf));

  ast_sc_fifo #(.READY_LATENCY(2), .ADDR_WIDTH(4), .STORE_FORWARD(1)) dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .snk_data_i(b_snk_data), .snk_valid_i(b_snk_valid), .snk_sop_i(b_snk_sop),
    .snk_eop_i(b_snk_eop), .snk_empty_i(b_snk_empty), .snk_ready_o(b_snk_ready),
    .src_data_o(b_src_data), .src_valid_o(b_src_valid), .src_sop_o(b_src_sop),
    .src_eop_o(b_src_eop), .src_empty_o(b_src_empty), .src_ready_i(b_src_ready),
    .fill_level_o(b_fill), .almost_full_o(b_af), .almost_empty_o(b_ae),
    .overflow_o(b_ovf));

  always #5 clk = ~clk;

  // Producer-side view of the grant: snk_ready as seen two cycles earlier.
  always @(posedge clk) begin
    a_h1 <= a_snk_ready;
    a_h2 <= a_h1;
    b_h1 <= b_snk_ready;
    b_h2 <= b_h1;
  end

  task automatic test_reset;
    a_src_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (a_snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_snk_ready: got %b expected 0", a_snk_ready); end
    tests_run++; if (a_src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_src_valid: got %b expected 0", a_src_valid); end
    tests_run++; if (a_fill !== 5'd0) begin tests_failed++; $display("[TB] FAIL rst_fill: got %0d expected 0", a_fill); end
    tests_run++; if (a_af !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_almost_full: got %b expected 0", a_af); end
    tests_run++; if (a_ae !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_almost_empty: got %b expected 1", a_ae); end
    tests_run++; if (a_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_overflow: got %b expected 0", a_ovf); end
    a_rst = 1'b0;
    a_src_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (a_snk_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rel_snk_ready: got %b expected 1", a_snk_ready); end
  endtask

  task automatic test_fill;
    int written;
    int exp_fill;
    int cyc;
    written = 0; exp_fill = 0; cyc = 0;
    while (written < 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      tests_run++; if (a_snk_ready !== (exp_fill < 14)) begin tests_failed++; $display("[TB] FAIL fill_snk_ready: got %b expected %b at fill %0d", a_snk_ready, (exp_fill < 14), exp_fill); end
      tests_run++; if (a_fill !== 5'(exp_fill)) begin tests_failed++; $display("[TB] FAIL fill_level: got %0d expected %0d", a_fill, exp_fill); end
      if (a_h2) begin
        a_snk_valid = 1'b1;
        a_snk_data  = 32'(written + 1);
        written++;
        exp_fill++;
      end else begin
        a_snk_valid = 1'b0;
      end
    end
    tests_run++; if (written != 16) begin tests_failed++; $display("[TB] FAIL fill_timeout: got %0d beats expected 16", written); end
    @(negedge clk);
    a_snk_valid = 1'b0;
    tests_run++; if (a_fill !== 5'd16) begin tests_failed++; $display("[TB] FAIL full_level: got %0d expected 16", a_fill); end
    tests_run++; if (a_snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_snk_ready: got %b expected 0", a_snk_ready); end
    tests_run++; if (a_af !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_almost_full: got %b expected 1", a_af); end
    tests_run++; if (a_ae !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_almost_empty: got %b expected 0", a_ae); end
    tests_run++; if (a_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_overflow: got %b expected 0", a_ovf); end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    a_snk_valid = 1'b1;
    a_snk_data  = 32'hDEADBEEF;
    @(negedge clk);
    a_snk_valid = 1'b0;
    tests_run++; if (a_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set: got %b expected 1", a_ovf); end
    tests_run++; if (a_fill !== 5'd16) begin tests_failed++; $display("[TB] FAIL ovf_fill: got %0d expected 16", a_fill); end
    repeat (3) @(negedge clk);
    tests_run++; if (a_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %b expected 1", a_ovf); end
  endtask

  task automatic test_drain;
    a_src_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++; if (a_src_valid !== (k >= 2)) begin tests_failed++; $display("[TB] FAIL drain_valid[%0d]: got %b expected %b", k, a_src_valid, (k >= 2)); end
      if (k >= 2) begin
        tests_run++; if (a_src_data !== 32'(k - 1)) begin tests_failed++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", k, a_src_data, 32'(k - 1)); end
      end
    end
    @(negedge clk);
    tests_run++; if (a_src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_end_valid: got %b expected 0", a_src_valid); end
    tests_run++; if (a_fill !== 5'd0) begin tests_failed++; $display("[TB] FAIL drain_end_fill: got %0d expected 0", a_fill); end
    tests_run++; if (a_ae !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_almost_empty: got %b expected 1", a_ae); end
    tests_run++; if (a_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_ovf_held: got %b expected 1", a_ovf); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    int          exp_fill;
    int          written;
    int          received;
    int          cyc;
    logic        exp_valid;
    logic        wr;
    exp_fill = 0; written = 0; received = 0; cyc = 0;
    a_src_ready = 1'b1;
    repeat (2) @(negedge clk);
    while (received < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      exp_valid = (exp_fill != 0);
      tests_run++; if (a_src_valid !== exp_valid) begin tests_failed++; $display("[TB] FAIL b2b_valid: got %b expected %b", a_src_valid, exp_valid); end
      tests_run++; if (a_fill !== 5'(exp_fill)) begin tests_failed++; $display("[TB] FAIL b2b_fill: got %0d expected %0d", a_fill, exp_fill); end
      if (exp_valid) begin
        tests_run++; if (a_src_data !== q[0]) begin tests_failed++; $display("[TB] FAIL b2b_data: got %h expected %h", a_src_data, q[0]); end
        void'(q.pop_front());
        received++;
      end
      wr = a_h2 && (written < 6);
      a_snk_valid = wr;
      if (wr) begin
        a_snk_data = 32'hA0 + 32'(written);
        q.push_back(a_snk_data);
        written++;
      end
      exp_fill = exp_fill + (wr ? 1 : 0) - (exp_valid ? 1 : 0);
    end
    a_snk_valid = 1'b0;
    tests_run++; if (received != 6) begin tests_failed++; $display("[TB] FAIL b2b_timeout: got %0d beats expected 6", received); end
  endtask

  task automatic test_reset_mid;
    int written;
    int cyc;
    written = 0; cyc = 0;
    a_src_ready = 1'b0;
    repeat (3) @(negedge clk);
    while (written < 7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      a_snk_valid = a_h2;
      if (a_h2) begin
        a_snk_data = 32'h100 + 32'(written);
        written++;
      end
    end
    @(negedge clk);
    a_snk_valid = 1'b0;
    tests_run++; if (a_fill !== 5'd7) begin tests_failed++; $display("[TB] FAIL mid_fill: got %0d expected 7", a_fill); end
    a_src_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (a_src_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_valid: got %b expected 1", a_src_valid); end
    tests_run++; if (a_src_data !== 32'h100) begin tests_failed++; $display("[TB] FAIL mid_head: got %h expected 00000100", a_src_data); end
    #1 a_rst = 1'b1;
    #1;
    tests_run++; if (a_fill !== 5'd0) begin tests_failed++; $display("[TB] FAIL mid_rst_fill: got %0d expected 0", a_fill); end
    tests_run++; if (a_src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", a_src_valid); end
    tests_run++; if (a_snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ready: got %b expected 0", a_snk_ready); end
    tests_run++; if (a_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_rst_ovf: got %b expected 0", a_ovf); end
    @(negedge clk);
    a_rst = 1'b0;
    a_src_ready = 1'b0;
    a_snk_valid = 1'b1;
    a_snk_data = 32'h55;
    @(negedge clk);
    a_snk_valid = 1'b0;
    tests_run++; if (a_snk_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rel_ready: got %b expected 1", a_snk_ready); end
    tests_run++; if (a_ovf !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_rel_ovf: got %b expected 1", a_ovf); end
    tests_run++; if (a_fill !== 5'd0) begin tests_failed++; $display("[TB] FAIL mid_rel_fill: got %0d expected 0", a_fill); end
  endtask

  task automatic test_store_forward;
    int   cyc;
    int   sent;
    int   recv;
    int   eop_cyc;
    logic exp_v;
    cyc = 0; sent = 0; recv = 0; eop_cyc = -1;
    b_src_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (b_snk_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sf_rst_ready: got %b expected 0", b_snk_ready); end
    b_rst = 1'b0;
    while (cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      exp_v = (eop_cyc >= 0) && (cyc > eop_cyc) && (cyc <= eop_cyc + 5);
      tests_run++; if (b_src_valid !== exp_v) begin tests_failed++; $display("[TB] FAIL sf_valid[%0d]: got %b expected %b", cyc, b_src_valid, exp_v); end
      if (exp_v) begin
        tests_run++; if (b_src_data !== 32'hC0 + 32'(recv)) begin tests_failed++; $display("[TB] FAIL sf_data[%0d]: got %h expected %h", recv, b_src_data, 32'hC0 + 32'(recv)); end
        tests_run++; if (b_src_sop !== (recv == 0)) begin tests_failed++; $display("[TB] FAIL sf_sop[%0d]: got %b expected %b", recv, b_src_sop, (recv == 0)); end
        tests_run++; if (b_src_eop !== (recv == 4)) begin tests_failed++; $display("[TB] FAIL sf_eop[%0d]: got %b expected %b", recv, b_src_eop, (recv == 4)); end
        if (recv == 4) begin
          tests_run++; if (b_src_empty !== 2'd2) begin tests_failed++; $display("[TB] FAIL sf_empty: got %0d expected 2", b_src_empty); end
        end
        recv++;
      end
      if (b_h2 && sent < 5) begin
        b_snk_valid = 1'b1;
        b_snk_data  = 32'hC0 + 32'(sent);
        b_snk_sop   = (sent == 0);
        b_snk_eop   = (sent == 4);
        b_snk_empty = (sent == 4) ? 2'd2 : 2'd0;
        if (sent == 4) eop_cyc = cyc;
        sent++;
      end else begin
        b_snk_valid = 1'b0;
        b_snk_sop   = 1'b0;
        b_snk_eop   = 1'b0;
        b_snk_empty = 2'd0;
      end
      if (eop_cyc >= 0 && cyc > eop_cyc + 5) break;
      cyc++;
    end
    tests_run++; if (recv != 5) begin tests_failed++; $display("[TB] FAIL sf_timeout: got %0d beats expected 5", recv); end
  endtask

  task automatic test_sf_cutthru;
    int   cyc;
    int   sent;
    int   recv;
    int   exp_fill;
    logic seen;
    cyc = 0; sent = 0; recv = 0; exp_fill = 0; seen = 1'b0;
    while (recv < 20 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!seen) begin
        tests_run++; if (b_src_valid !== (exp_fill == 16)) begin tests_failed++; $display("[TB] FAIL ct_hold_valid: got %b expected %b at fill %0d", b_src_valid, (exp_fill == 16), exp_fill); end
        tests_run++; if (b_fill !== 5'(exp_fill)) begin tests_failed++; $display("[TB] FAIL ct_fill: got %0d expected %0d", b_fill, exp_fill); end
      end
      if (b_src_valid) begin
        seen = 1'b1;
        tests_run++; if (b_src_data !== 32'hE00 + 32'(recv)) begin tests_failed++; $display("[TB] FAIL ct_data[%0d]: got %h expected %h", recv, b_src_data, 32'hE00 + 32'(recv)); end
        tests_run++; if (b_src_eop !== (recv == 19)) begin tests_failed++; $display("[TB] FAIL ct_eop[%0d]: got %b expected %b", recv, b_src_eop, (recv == 19)); end
        recv++;
      end
      if (b_h2 && sent < 20) begin
        b_snk_valid = 1'b1;
        b_snk_data  = 32'hE00 + 32'(sent);
        b_snk_sop   = (sent == 0);
        b_snk_eop   = (sent == 19);
        b_snk_empty = 2'd0;
        sent++;
        if (!seen) exp_fill++;
      end else begin
        b_snk_valid = 1'b0;
        b_snk_sop   = 1'b0;
        b_snk_eop   = 1'b0;
      end
    end
    b_snk_valid = 1'b0;
    tests_run++; if (recv != 20) begin tests_failed++; $display("[TB] FAIL ct_timeout: got %0d beats expected 20", recv); end
    @(negedge clk);
    tests_run++; if (b_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL ct_overflow: got %b expected 0", b_ovf); end
    tests_run++; if (b_fill !== 5'd0) begin tests_failed++; $display("[TB] FAIL ct_end_fill: got %0d expected 0", b_fill); end
    tests_run++; if (b_src_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ct_end_valid: got %b expected 0", b_src_valid); end
  endtask

  initial begin
    clk = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    a_h1 = 1'b0; a_h2 = 1'b0; b_h1 = 1'b0; b_h2 = 1'b0;
    a_rst = 1'b1; a_snk_valid = 1'b0; a_snk_sop = 1'b0; a_snk_eop = 1'b0;
    a_snk_empty = 2'd0; a_snk_data = 32'd0; a_src_ready = 1'b0;
    b_rst = 1'b1; b_snk_valid = 1'b0; b_snk_sop = 1'b0; b_snk_eop = 1'b0;
    b_snk_empty = 2'd0; b_snk_data = 32'd0; b_src_ready = 1'b0;
    test_reset;
    test_fill;
    test_overflow;
    test_drain;
    test_back_to_back;
    test_reset_mid;
    test_store_forward;
    test_sf_cutthru;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
